// File: rtl/mom_filter_top.sv
// mom_filter_top
// ---------------------------------------------------------------------------
// Streaming 3x3 median-of-medians filter over a 5-row x 14-column window of
// 8-bit pixels. Each clock consumes one window and registers the 3x12
// interior outputs as four 3x3 blocks, so results appear one cycle later.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous, active-low reset
//   pixel_in     in   560-bit window; row r at [559-112r -: 112],
//                     column c within a row at [559-112r-8c -: 8]
//   valid        out  1 once the first post-reset window has been registered
//   block_out_k  out  72-bit block k (output columns 3k..3k+2), row-major,
//                     MSB first: O(i,j) at [71-24i-8(j-3k) -: 8]
//
// Flow control: there is no handshake. Every rising edge with rst_n high
// takes pixel_in as a new window and overwrites the block outputs; valid
// rises on the first such edge and stays high until the next reset.
//
// Configuration macro
//   MOM_CHECK_EN  when defined, adds a simulation-only sort-based checker
//                 that reports any output differing from a recomputation of
//                 the previous window. Port behaviour is unchanged.
// ---------------------------------------------------------------------------
module mom_filter_top (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [559:0] pixel_in,
  output logic         valid,
  output logic [71:0]  block_out_0,
  output logic [71:0]  block_out_1,
  output logic [71:0]  block_out_2,
  output logic [71:0]  block_out_3
);

  // Median of three via min/max network: max(min(a,b), min(max(a,b), c)).
  function automatic logic [7:0] med3(input logic [7:0] a,
                                      input logic [7:0] b,
                                      input logic [7:0] c);
    logic [7:0] lo;
    logic [7:0] hi;
    logic [7:0] hc;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    hc = (hi < c) ? hi : c;
    return (lo > hc) ? lo : hc;
  endfunction

  logic [7:0]   px [5][14];
  logic [7:0]   rm [5][12];
  logic [287:0] result;

  always_comb begin
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 14; c++) begin
        px[r][c] = pixel_in[559 - 112*r - 8*c -: 8];
      end
    end
  end

  // Row medians are shared: each one feeds up to three vertically
  // overlapping neighbourhoods.
  always_comb begin
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < 12; j++) begin
        rm[r][j] = med3(px[r][j], px[r][j+1], px[r][j+2]);
      end
    end
  end

  // result holds block 0 in its top 72 bits, block 3 in its bottom 72 bits.
  always_comb begin
    result = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 12; j++) begin
        result[287 - 72*(j/3) - 24*i - 8*(j%3) -: 8] =
          med3(rm[i][j], rm[i+1][j], rm[i+2][j]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid       <= 1'b0;
      block_out_0 <= '0;
      block_out_1 <= '0;
      block_out_2 <= '0;
      block_out_3 <= '0;
    end else begin
      valid       <= 1'b1;
      block_out_0 <= result[287:216];
      block_out_1 <= result[215:144];
      block_out_2 <= result[143:72];
      block_out_3 <= result[71:0];
    end
  end

`ifdef MOM_CHECK_EN
  // Simulation-only cross-check. The window is captured on each rising
  // edge; on the following falling edge the registered blocks must match a
  // sort-based recomputation of that window.
  logic [559:0] chk_win;

  function automatic logic [7:0] sort_mid(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic [7:0] c);
    logic [7:0] v [3];
    logic [7:0] t;
    v[0] = a; v[1] = b; v[2] = c;
    for (int p = 0; p < 2; p++) begin
      for (int q = 0; q < 2 - p; q++) begin
        if (v[q] > v[q+1]) begin
          t = v[q]; v[q] = v[q+1]; v[q+1] = t;
        end
      end
    end
    return v[1];
  endfunction

  always @(posedge clk) chk_win <= pixel_in;

  always @(negedge clk) begin
    if (rst_n && valid) begin
      logic [7:0]  m [3];
      logic [7:0]  e;
      logic [7:0]  g;
      logic [71:0] blk;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 12; j++) begin
          for (int t = 0; t < 3; t++) begin
            m[t] = sort_mid(chk_win[559 - 112*(i+t) - 8*j       -: 8],
                            chk_win[559 - 112*(i+t) - 8*(j+1)   -: 8],
                            chk_win[559 - 112*(i+t) - 8*(j+2)   -: 8]);
          end
          e = sort_mid(m[0], m[1], m[2]);
          case (j / 3)
            0:       blk = block_out_0;
            1:       blk = block_out_1;
            2:       blk = block_out_2;
            default: blk = block_out_3;
          endcase
          g = blk[71 - 24*i - 8*(j%3) -: 8];
          if (g !== e)
            $display("mom_check: row %0d col %0d expected %02h got %02h",
                     i, j, e, g);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_mom_filter_top.sv
// tb_mom_filter_top
// Bench for mom_filter_top: reset, flat, impulse, gradient, a full-frame
// tiled stream and a mid-stream reset. Expected values come from a
// sort-based median model working on pixel arrays.
module tb_mom_filter_top;

  // ---------------- clock / reset ----------------
  logic         clk;
  logic         rst_n;
  logic [559:0] pixel_in;
  logic         valid;
  logic [71:0]  block_out_0;
  logic [71:0]  block_out_1;
  logic [71:0]  block_out_2;
  logic [71:0]  block_out_3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mom_filter_top dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_in    (pixel_in),
    .valid       (valid),
    .block_out_0 (block_out_0),
    .block_out_1 (block_out_1),
    .block_out_2 (block_out_2),
    .block_out_3 (block_out_3)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  logic [7:0]   win   [5][14];
  logic [7:0]   frame [482][638];
  logic [7:0]   filt  [480][636];
  logic [287:0] exp_q [$];

  function automatic logic [7:0] mid3(input logic [7:0] a,
                                      input logic [7:0] b,
                                      input logic [7:0] c);
    logic [7:0] v [3];
    logic [7:0] t;
    v[0] = a; v[1] = b; v[2] = c;
    for (int p = 0; p < 2; p++)
      for (int q = 0; q < 2 - p; q++)
        if (v[q] > v[q+1]) begin
          t = v[q]; v[q] = v[q+1]; v[q+1] = t;
        end
    return v[1];
  endfunction

  function automatic logic [559:0] pack_window();
    logic [559:0] w;
    w = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 14; c++)
        w[559 - 112*r - 8*c -: 8] = win[r][c];
    return w;
  endfunction

  // Four blocks concatenated, block 0 most significant.
  function automatic logic [287:0] model_window();
    logic [287:0] o;
    logic [7:0]   m [3];
    o = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 12; j++) begin
        for (int t = 0; t < 3; t++)
          m[t] = mid3(win[i+t][j], win[i+t][j+1], win[i+t][j+2]);
        o[287 - 72*(j/3) - 24*i - 8*(j%3) -: 8] = mid3(m[0], m[1], m[2]);
      end
    return o;
  endfunction

  function automatic void random_window();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 14; c++)
        win[r][c] = 8'($urandom_range(0, 255));
  endfunction

  // ---------------- checks (inline per task) ----------------
  task automatic check_blocks(input string name, input logic [287:0] e);
    logic [71:0] got [4];
    logic [71:0] ex  [4];
    got[0] = block_out_0; got[1] = block_out_1;
    got[2] = block_out_2; got[3] = block_out_3;
    for (int k = 0; k < 4; k++) begin
      ex[k] = e[287 - 72*k -: 72];
      checks++;
      if (got[k] !== ex[k]) begin
        failures++;
        $display("FAIL %s blk%0d: got %h expected %h", name, k, got[k], ex[k]);
      end
    end
  endtask

  task automatic check_valid(input string name, input logic e);
    checks++;
    if (valid !== e) begin
      failures++;
      $display("FAIL %s valid: got %b expected %b", name, valid, e);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      random_window();
      pixel_in = pack_window();
      @(posedge clk);
    end
    #1;
    check_valid("reset_hold", 1'b0);
    check_blocks("reset_hold", '0);
    rst_n = 1'b1;
    random_window();
    pixel_in = pack_window();
    @(posedge clk); #1;
    check_valid("reset_release", 1'b1);
    check_blocks("reset_release", model_window());
  endtask

  task automatic test_flat();
    logic [287:0] e;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 14; c++)
        win[r][c] = 8'h5A;
    pixel_in = pack_window();
    e = {36{8'h5A}};
    @(posedge clk); #1;
    check_blocks("flat", e);
  endtask

  task automatic test_impulse();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 14; c++)
        win[r][c] = 8'h00;
    win[2][6] = 8'hFF;
    pixel_in = pack_window();
    @(posedge clk); #1;
    check_blocks("impulse", '0);
  endtask

  task automatic test_gradient();
    logic [287:0] e;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 14; c++)
        win[r][c] = 8'(16 * c);
    pixel_in = pack_window();
    e = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 12; j++)
        e[287 - 72*(j/3) - 24*i - 8*(j%3) -: 8] = 8'(16 * (j + 1));
    @(posedge clk); #1;
    check_blocks("gradient", e);
    checks++;
    if (block_out_0[71:48] !== 24'h102030) begin
      failures++;
      $display("FAIL gradient_b0r0: got %h expected 102030", block_out_0[71:48]);
    end
    checks++;
    if (block_out_3[23:0] !== 24'hA0B0C0) begin
      failures++;
      $display("FAIL gradient_b3r2: got %h expected a0b0c0", block_out_3[23:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [287:0] e;
    logic [7:0]   m [3];
    for (int y = 0; y < 482; y++)
      for (int x = 0; x < 638; x++)
        frame[y][x] = 8'($urandom_range(0, 255));
    for (int y = 0; y < 480; y++)
      for (int x = 0; x < 636; x++) begin
        for (int t = 0; t < 3; t++)
          m[t] = mid3(frame[y+t][x], frame[y+t][x+1], frame[y+t][x+2]);
        filt[y][x] = mid3(m[0], m[1], m[2]);
      end
    for (int n = 0; n < 160; n++)
      for (int mm = 0; mm < 53; mm++) begin
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 14; c++)
            win[r][c] = frame[3*n + r][12*mm + c];
        pixel_in = pack_window();
        e = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 12; j++)
            e[287 - 72*(j/3) - 24*i - 8*(j%3) -: 8] = filt[3*n + i][12*mm + j];
        exp_q.push_back(e);
        @(posedge clk); #1;
        check_blocks("stream", exp_q.pop_front());
        if (mm == 0) check_valid("stream", 1'b1);
      end
  endtask

  task automatic test_mid_reset();
    repeat (4) begin
      random_window();
      pixel_in = pack_window();
      @(posedge clk); #1;
      check_blocks("pre_reset", model_window());
    end
    random_window();
    pixel_in = pack_window();
    rst_n = 1'b0;
    #1;
    check_valid("async_reset", 1'b0);
    check_blocks("async_reset", '0);
    @(posedge clk); #1;
    check_valid("reset_edge", 1'b0);
    check_blocks("reset_edge", '0);
    rst_n = 1'b1;
    random_window();
    pixel_in = pack_window();
    @(posedge clk); #1;
    check_valid("after_reset", 1'b1);
    check_blocks("after_reset", model_window());
    repeat (3) begin
      random_window();
      pixel_in = pack_window();
      @(posedge clk); #1;
      check_blocks("post_reset", model_window());
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_n    = 1'b0;
    pixel_in = '0;
    test_reset();
    test_flat();
    test_impulse();
    test_gradient();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
